bitrev_rr_arbiter: RTL

- Shares one bit-reversal datapath between NUM_REQ independent requesters.
- Arbitration is round-robin over valid/ready request channels.
- The chosen word is reversed (dout[i] = din[DATA_WIDTH-1-i]) and registered into a single output stage with valid/ready backpressure, tagged with the winner's index.
- Sits between several producer engines and one downstream consumer that needs bit-reversed words, e.g. FFT address reordering or CRC reflection.

---
 rtl/bitrev_pkg.sv | 27 ++
 rtl/bitrev_rr_arbiter_bit_reverse.sv | 23 ++
 rtl/bitrev_rr_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bitrev_pkg.sv
// ---------------------------------------------------------------------------
// bitrev_pkg
// Shared helpers for the bit-reversal round-robin arbiter:
//   id_width : width of a requester index (clog2 with a floor of one bit)
//   rr_next  : round-robin pointer successor with wrap to zero
// ---------------------------------------------------------------------------
package bitrev_pkg;

    // Width needed to index n requesters; a single requester still gets one bit
    function automatic int id_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Pointer that follows index cur, wrapping from n-1 back to 0
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        if ((cur + 32'd1) >= n) begin
            return 32'd0;
        end else begin
            return cur + 32'd1;
        end
    endfunction

endpackage : bitrev_pkg

// File: rtl/bitrev_rr_arbiter_bit_reverse.sv
// ---------------------------------------------------------------------------
// bit_reverse
// Purely combinational bit-order reversal: dout[i] = din[DATA_WIDTH-1-i].
// Ports:
//   din  - input word
//   dout - input word with bit order mirrored
// ---------------------------------------------------------------------------
module bit_reverse #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    // Mirror the bit order of the input word
    always_comb begin
        dout = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            dout[i] = din[DATA_WIDTH-1-i];
        end
    end

endmodule : bit_reverse

// File: rtl/bitrev_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bitrev_rr_arbiter
// Shares one bit-reversal datapath between NUM_REQ valid/ready requesters.
// A round-robin pick selects one requester per cycle whenever the single
// output register can accept a word; the chosen word is bit-reversed and
// registered together with the winner's index.
// Ports:
//   clk       - rising-edge clock
//   resetn    - asynchronous active-low reset
//   req_valid - per-requester valid
//   req_data  - flattened request words, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready - per-requester ready, one-hot or zero (combinational)
//   out_valid - output word valid (registered)
//   out_ready - consumer ready
//   out_data  - bit-reversed winning word (registered)
//   out_id    - index of the requester that produced out_data (registered)
// ---------------------------------------------------------------------------
module bitrev_rr_arbiter
    import bitrev_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id
);

    // Lowest index with its bit set; zero when the vector is empty
    function automatic logic [ID_WIDTH-1:0] lowest_set(input logic [NUM_REQ-1:0] vec);
        logic [ID_WIDTH-1:0] res;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            res = vec[k] ? ID_WIDTH'(k) : res;
        end
        return res;
    endfunction

    // Registered state
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q,    out_id_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q,    rr_ptr_d;

    // Arbitration and datapath signals
    logic                  load_s;
    logic                  any_req_s;
    logic                  grant_s;
    logic [NUM_REQ-1:0]    hi_mask_s;
    logic [NUM_REQ-1:0]    hi_req_s;
    logic [ID_WIDTH-1:0]   winner_s;
    logic [DATA_WIDTH-1:0] mux_data_s;
    logic [DATA_WIDTH-1:0] rev_data_s;

    // Round-robin pick: requesters at or above the pointer take priority,
    // and only if none of them is valid does the search wrap to index 0.
    // The grant is gated by resetn so req_ready stays low while in reset.
    always_comb begin
        load_s    = !out_valid_q || out_ready;
        any_req_s = |req_valid;
        grant_s   = resetn && load_s && any_req_s;
        hi_mask_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hi_mask_s[k] = (ID_WIDTH'(k) >= rr_ptr_q);
        end
        hi_req_s = req_valid & hi_mask_s;
        if (|hi_req_s) begin
            winner_s = lowest_set(hi_req_s);
        end else begin
            winner_s = lowest_set(req_valid);
        end
    end

    // One-hot ready towards the winner, and winner data selection
    always_comb begin
        req_ready  = '0;
        mux_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = grant_s && (winner_s == ID_WIDTH'(k));
            mux_data_s   = (winner_s == ID_WIDTH'(k)) ?
                           req_data[k*DATA_WIDTH +: DATA_WIDTH] : mux_data_s;
        end
    end

    bit_reverse #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_reverse (
        .din  (mux_data_s),
        .dout (rev_data_s)
    );

    // Next-state for the output stage and pointer; data/id only move on a grant
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_s) begin
            out_valid_d = 1'b1;
            out_data_d  = rev_data_s;
            out_id_d    = winner_s;
            rr_ptr_d    = ID_WIDTH'(rr_next(32'(winner_s), 32'(NUM_REQ)));
        end else if (load_s) begin
            // Slot is empty or draining with nothing to refill it
            out_valid_d = 1'b0;
        end else begin
            // Stalled: hold everything
            out_valid_d = out_valid_q;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule : bitrev_rr_arbiter
